register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
Parametrised successor to the CPU's two-entry register file. Provides NUM_REGS registers of DATA_W bits, two independent combinational read ports, one synchronous write port with in-place LOAD/INC/DEC/CLR operations, optional write-through bypass, and an optional hardwired-zero R0. A flattened view of all registers is exported for debug and bench observation.

Parameters:
DATA_W, 4, register width in bits (>=1)
NUM_REGS, 4, number of registers (2..256; need not be a power of two)
ADDR_W, 2, address width; must satisfy 2**ADDR_W >= NUM_REGS
BYPASS, 1, 1 = read port returns the write data of a same-cycle write to the same address; 0 = read returns stored value
ZERO_R0, 0, 1 = register 0 always reads 0 and ignores writes

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
we  in  1  write enable
waddr  in  ADDR_W  write address
wop  in  2  write op: 00 LOAD, 01 INC, 10 DEC, 11 CLR
wdata  in  DATA_W  write data (used by LOAD only)
raddr_a  in  ADDR_W  read port A address
rdata_a  out  DATA_W  read port A data (combinational)
raddr_b  in  ADDR_W  read port B address
rdata_b  out  DATA_W  read port B data (combinational)
wr_done  out  1  one-cycle pulse, cycle after an accepted write
wr_result  out  DATA_W  value committed by the last accepted write (registered)
regs_flat  out  NUM_REGS*DATA_W  all registers; reg i at bits [i*DATA_W +: DATA_W]

Behaviour:
- Reset (sync, on clk edge with reset=1): all registers <= 0, wr_done <= 0, wr_result <= 0. Reset overrides any concurrent write; the write is discarded, no wr_done follows.
- Write accepted iff we=1, reset=0, waddr < NUM_REGS, and not (ZERO_R0=1 and waddr=0).
- Next value nv for an accepted write: LOAD -> wdata; INC -> reg+1; DEC -> reg-1; CLR -> 0. Arithmetic is modulo 2**DATA_W (INC of all-ones -> 0, DEC of 0 -> all-ones). No flags.
- Register updates on the edge; visible on regs_flat and non-bypassed reads the following cycle.
- wr_done: 1 for exactly one cycle after each accepted write, else 0. Back-to-back writes hold wr_done high continuously. Rejected writes (out of range, R0 with ZERO_R0) produce no pulse; wr_result holds its value.
- wr_result <= nv on each accepted write.
- Reads: rdata_x = stored register[raddr_x], zero-latency combinational.
- raddr_x >= NUM_REGS -> rdata_x = 0.
- ZERO_R0=1: raddr_x=0 -> 0 regardless of bypass; regs_flat slice 0 is 0.
- BYPASS=1 and accepted write this cycle with waddr == raddr_x -> rdata_x = nv (op-resolved, e.g. INC shows reg+1). Both ports bypass independently; both may target the same address. BYPASS ignores reset (reads during reset show stored values).
- Unused upper addresses consume no storage.
- Degenerate NUM_REGS=2, DATA_W=4, BYPASS=0, ZERO_R0=0, one read port used matches the legacy two-register file cycle-for-cycle.

Test Plan:
- Reset then LOAD 5 to r0, LOAD 9 to r1 -> next cycle regs_flat=16'h0095; rdata_a(raddr 0)=5, rdata_b(raddr 1)=9; wr_done high two cycles, wr_result 5 then 9.
- r2=4'hF, INC r2 -> r2=0, wr_result=0; DEC r2 -> r2=4'hF; CLR r2 -> 0 (wrap-around).
- BYPASS=1: r3=7, same cycle we=1 INC r3 with raddr_a=raddr_b=3 -> rdata_a=rdata_b=8 combinationally before edge; BYPASS=0 same stimulus -> 7 until edge, then 8.
- ZERO_R0=1: LOAD 12 to r0 -> rdata_a(0)=0, no wr_done, regs_flat slice 0 = 0; LOAD 12 to r1 -> r1=12, wr_done pulse.
- NUM_REGS=3, ADDR_W=2: LOAD 6 to addr 3 -> no state change, no wr_done; raddr_a=3 -> 0.
- Registers loaded, assert reset with concurrent we LOAD 10 to r1 -> all registers 0, wr_done=0, wr_result=0 next cycle.

Source files
------------

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_REGS x DATA_W storage, two combinational read ports,
// one synchronous write port with LOAD/INC/DEC/CLR, optional write-through and hardwired R0.
module register_file_mp #(
    parameter int DATA_W   = 4,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_R0  = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            waddr,
    input  logic [1:0]                   wop,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [ADDR_W-1:0]            raddr_a,
    output logic [DATA_W-1:0]            rdata_a,
    input  logic [ADDR_W-1:0]            raddr_b,
    output logic [DATA_W-1:0]            rdata_b,
    output logic                         wr_done,
    output logic [DATA_W-1:0]            wr_result,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              wr_done_q, wr_done_d;
    logic [DATA_W-1:0] wr_result_q, wr_result_d;
    logic              wr_acc;
    logic [DATA_W-1:0] cur_val;
    logic [DATA_W-1:0] nv;

    function automatic logic addr_hit(input logic [ADDR_W-1:0] a, input int idx);
        return 32'(a) == 32'(idx);
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(NUM_REGS);
    endfunction

    // Write path: resolve the op against the currently stored value of the target.
    always_comb begin
        cur_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_hit(waddr, i)) begin
                cur_val = regs_q[i];
            end
        end

        wr_acc = we && !reset && in_range(waddr) && !((ZERO_R0 != 0) && (waddr == '0));

        case (wop)
            OP_LOAD: nv = wdata;
            OP_INC:  nv = cur_val + DATA_W'(1);
            OP_DEC:  nv = cur_val - DATA_W'(1);
            default: nv = '0;
        endcase

        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_acc && addr_hit(waddr, i)) begin
                regs_d[i] = nv;
            end
        end

        wr_done_d   = wr_acc;
        wr_result_d = wr_acc ? nv : wr_result_q;
    end

    // Read ports; wr_acc already excludes reset, out-of-range and hardwired R0,
    // so the bypass can never leak a value those cases must hide.
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!((ZERO_R0 != 0) && (i == 0))) begin
                if (addr_hit(raddr_a, i)) rdata_a = regs_q[i];
                if (addr_hit(raddr_b, i)) rdata_b = regs_q[i];
            end
        end
        if ((BYPASS != 0) && wr_acc && (waddr == raddr_a)) rdata_a = nv;
        if ((BYPASS != 0) && wr_acc && (waddr == raddr_b)) rdata_b = nv;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_done_q   <= 1'b0;
            wr_result_q <= '0;
        end else begin
            regs_q      <= regs_d;
            wr_done_q   <= wr_done_d;
            wr_result_q <= wr_result_d;
        end
    end

    assign wr_done   = wr_done_q;
    assign wr_result = wr_result_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        if ((ZERO_R0 != 0) && (g == 0)) begin : g_zero
            assign regs_flat[g*DATA_W +: DATA_W] = '0;
        end else begin : g_reg
            assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp: one bypassing 4-entry instance and one
// 3-entry instance with hardwired R0 and no bypass.
module tb_register_file_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Instance A: DATA_W=4, NUM_REGS=4, BYPASS=1, ZERO_R0=0
    logic        a_reset, a_we;
    logic [1:0]  a_waddr, a_wop, a_raddr_a, a_raddr_b;
    logic [3:0]  a_wdata, a_rdata_a, a_rdata_b, a_wr_result;
    logic        a_wr_done;
    logic [15:0] a_regs_flat;

    register_file_mp #(.DATA_W(4), .NUM_REGS(4), .ADDR_W(2), .BYPASS(1), .ZERO_R0(0)) u_a (
        .clk(clk), .reset(a_reset), .we(a_we), .waddr(a_waddr), .wop(a_wop), .wdata(a_wdata),
        .raddr_a(a_raddr_a), .rdata_a(a_rdata_a), .raddr_b(a_raddr_b), .rdata_b(a_rdata_b),
        .wr_done(a_wr_done), .wr_result(a_wr_result), .regs_flat(a_regs_flat)
    );

    // Instance B: DATA_W=4, NUM_REGS=3, BYPASS=0, ZERO_R0=1
    logic        b_reset, b_we;
    logic [1:0]  b_waddr, b_wop, b_raddr_a, b_raddr_b;
    logic [3:0]  b_wdata, b_rdata_a, b_rdata_b, b_wr_result;
    logic        b_wr_done;
    logic [11:0] b_regs_flat;

    register_file_mp #(.DATA_W(4), .NUM_REGS(3), .ADDR_W(2), .BYPASS(0), .ZERO_R0(1)) u_b (
        .clk(clk), .reset(b_reset), .we(b_we), .waddr(b_waddr), .wop(b_wop), .wdata(b_wdata),
        .raddr_a(b_raddr_a), .rdata_a(b_rdata_a), .raddr_b(b_raddr_b), .rdata_b(b_rdata_b),
        .wr_done(b_wr_done), .wr_result(b_wr_result), .regs_flat(b_regs_flat)
    );

    logic [3:0] sb_a[$];
    logic [3:0] sb_b[$];

    // Monitors: every wr_done pulse must match the oldest expected commit value.
    always @(negedge clk) begin
        if (a_wr_done === 1'b1) begin
            if (sb_a.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL a_unexpected_wr_done actual=1 required=0");
            end else begin
                chk("a_wr_result", 32'(a_wr_result), 32'(sb_a.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (b_wr_done === 1'b1) begin
            if (sb_b.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL b_unexpected_wr_done actual=1 required=0");
            end else begin
                chk("b_wr_result", 32'(b_wr_result), 32'(sb_b.pop_front()));
            end
        end
    end

    localparam logic [1:0] LOAD = 2'b00, INC = 2'b01, DEC = 2'b10, CLR = 2'b11;

    task automatic a_wr(input logic [1:0] addr, input logic [1:0] op, input logic [3:0] d,
                        input bit push, input logic [3:0] exp);
        @(negedge clk);
        a_reset = 1'b0; a_we = 1'b1; a_waddr = addr; a_wop = op; a_wdata = d;
        if (push) sb_a.push_back(exp);
    endtask

    task automatic a_idle();
        @(negedge clk);
        a_reset = 1'b0; a_we = 1'b0;
    endtask

    task automatic b_wr(input logic [1:0] addr, input logic [1:0] op, input logic [3:0] d,
                        input bit push, input logic [3:0] exp);
        @(negedge clk);
        b_reset = 1'b0; b_we = 1'b1; b_waddr = addr; b_wop = op; b_wdata = d;
        if (push) sb_b.push_back(exp);
    endtask

    task automatic b_idle();
        @(negedge clk);
        b_reset = 1'b0; b_we = 1'b0;
    endtask

    initial begin
        a_reset = 1'b1; a_we = 1'b0; a_waddr = '0; a_wop = LOAD; a_wdata = '0;
        a_raddr_a = '0; a_raddr_b = '0;
        b_reset = 1'b1; b_we = 1'b0; b_waddr = '0; b_wop = LOAD; b_wdata = '0;
        b_raddr_a = '0; b_raddr_b = '0;
        repeat (2) @(negedge clk);
        chk("a_reset_flat", 32'(a_regs_flat), 32'h0);
        chk("a_reset_done", 32'(a_wr_done), 32'h0);
        chk("a_reset_result", 32'(a_wr_result), 32'h0);
        chk("b_reset_flat", 32'(b_regs_flat), 32'h0);

        // ---- Instance A: basic loads ----
        a_wr(2'd0, LOAD, 4'd5, 1'b1, 4'd5);
        a_wr(2'd1, LOAD, 4'd9, 1'b1, 4'd9);
        a_idle();
        a_raddr_a = 2'd0; a_raddr_b = 2'd1;
        #1;
        chk("a_flat_after_loads", 32'(a_regs_flat), 32'h0095);
        chk("a_rdata_a_r0", 32'(a_rdata_a), 32'd5);
        chk("a_rdata_b_r1", 32'(a_rdata_b), 32'd9);

        // ---- Instance A: wrap-around on r2 ----
        a_wr(2'd2, LOAD, 4'hF, 1'b1, 4'hF);
        a_wr(2'd2, INC, 4'h3, 1'b1, 4'h0);
        a_idle(); #1;
        chk("a_inc_wrap", 32'(a_regs_flat[11:8]), 32'h0);
        a_wr(2'd2, DEC, 4'h3, 1'b1, 4'hF);
        a_idle(); #1;
        chk("a_dec_wrap", 32'(a_regs_flat[11:8]), 32'hF);
        a_wr(2'd2, CLR, 4'h3, 1'b1, 4'h0);
        a_idle(); #1;
        chk("a_clr", 32'(a_regs_flat[11:8]), 32'h0);

        // ---- Instance A: bypass of an INC on both ports ----
        a_wr(2'd3, LOAD, 4'd7, 1'b1, 4'd7);
        a_raddr_a = 2'd3; a_raddr_b = 2'd3;
        a_wr(2'd3, INC, 4'd0, 1'b1, 4'd8);
        #1;
        chk("a_bypass_a", 32'(a_rdata_a), 32'd8);
        chk("a_bypass_b", 32'(a_rdata_b), 32'd8);
        chk("a_flat_before_edge", 32'(a_regs_flat[15:12]), 32'd7);
        a_idle(); #1;
        chk("a_r3_after_inc", 32'(a_rdata_a), 32'd8);

        // ---- Instance A: reset overrides a concurrent write; no bypass during reset ----
        @(negedge clk);
        a_reset = 1'b1; a_we = 1'b1; a_waddr = 2'd1; a_wop = LOAD; a_wdata = 4'd10;
        a_raddr_a = 2'd1;
        #1;
        chk("a_rd_during_reset", 32'(a_rdata_a), 32'd9);
        a_idle(); #1;
        chk("a_reset_wr_flat", 32'(a_regs_flat), 32'h0);
        chk("a_reset_wr_done", 32'(a_wr_done), 32'h0);
        chk("a_reset_wr_result", 32'(a_wr_result), 32'h0);

        // ---- Instance B: hardwired R0 ----
        b_raddr_a = 2'd0; b_raddr_b = 2'd1;
        b_wr(2'd0, LOAD, 4'd12, 1'b0, 4'd0);
        #1;
        chk("b_r0_read_during_wr", 32'(b_rdata_a), 32'd0);
        b_idle(); #1;
        chk("b_r0_read", 32'(b_rdata_a), 32'd0);
        chk("b_r0_flat", 32'(b_regs_flat[3:0]), 32'd0);
        chk("b_r0_no_result", 32'(b_wr_result), 32'd0);
        b_wr(2'd1, LOAD, 4'd12, 1'b1, 4'd12);
        b_idle(); #1;
        chk("b_r1_flat", 32'(b_regs_flat), 32'h0C0);
        chk("b_r1_read", 32'(b_rdata_b), 32'd12);

        // ---- Instance B: no bypass ----
        b_wr(2'd2, LOAD, 4'd7, 1'b1, 4'd7);
        b_raddr_a = 2'd2; b_raddr_b = 2'd2;
        b_wr(2'd2, INC, 4'd0, 1'b1, 4'd8);
        #1;
        chk("b_nobypass_a", 32'(b_rdata_a), 32'd7);
        chk("b_nobypass_b", 32'(b_rdata_b), 32'd7);
        b_idle(); #1;
        chk("b_after_edge_a", 32'(b_rdata_a), 32'd8);

        // ---- Instance B: out-of-range address ----
        b_raddr_a = 2'd3;
        b_wr(2'd3, LOAD, 4'd6, 1'b0, 4'd0);
        #1;
        chk("b_oor_read", 32'(b_rdata_a), 32'd0);
        b_idle(); #1;
        chk("b_oor_flat", 32'(b_regs_flat), 32'h8C0);
        chk("b_oor_result_held", 32'(b_wr_result), 32'd8);

        b_wr(2'd1, DEC, 4'd0, 1'b1, 4'd11);
        b_idle(); #1;
        chk("b_dec_r1", 32'(b_regs_flat[7:4]), 32'd11);

        repeat (3) @(negedge clk);
        #1;
        chk("a_scoreboard_drained", 32'(sb_a.size()), 32'd0);
        chk("b_scoreboard_drained", 32'(sb_b.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
